// File: rtl/mem_ctrl_if.sv
// Request/response and external byte-bus signals of the memory controller.
// The slave modport is the controller; the master modport is the CPU/memory side.
interface mem_ctrl_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        clear;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_res;
  logic        data_valid;
  logic        data_wr;
  logic [2:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_value;
  logic        data_ready;
  logic [31:0] data_res;

  modport slave (
    input  mem_din, io_buffer_full, clear,
    input  inst_valid, inst_addr,
    input  data_valid, data_wr, data_size, data_addr, data_value,
    output mem_dout, mem_a, mem_wr,
    output inst_ready, inst_res,
    output data_ready, data_res
  );

  modport master (
    output mem_din, io_buffer_full, clear,
    output inst_valid, inst_addr,
    output data_valid, data_wr, data_size, data_addr, data_value,
    input  mem_dout, mem_a, mem_wr,
    input  inst_ready, inst_res,
    input  data_ready, data_res
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store
// ports onto an 8-bit bus, assembling little-endian results with extension.
module mem_ctrl (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [31:0] buf_reg;
  logic [31:0] mem_a_reg;
  logic [31:0] inst_res_reg;
  logic [31:0] data_res_reg;
  logic [2:0]  n_reg;
  logic [2:0]  k_reg;
  logic [2:0]  size_reg;
  logic        owner_data_reg;
  logic        wr_reg;
  logic [7:0]  mem_dout_reg;
  logic        mem_wr_reg;
  logic        inst_ready_reg;
  logic        data_ready_reg;
  logic        rdy_q_reg;
  logic [7:0]  din_save_reg;

  logic [2:0]  k_inc;
  logic [7:0]  din_cap;
  logic [31:0] buf_next;
  logic [31:0] load_ext;
  logic [7:0]  wr_byte;
  logic        store_blocked;
  logic [2:0]  req_n;

  assign k_inc = k_reg + 3'd1;

  // The byte answering the last address shown while enabled; after a freeze
  // that byte arrived during the first frozen cycle and was saved then.
  assign din_cap = rdy_q_reg ? bus.mem_din : din_save_reg;

  // Byte k-1 is on the bus while index k is being driven.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign buf_next[8*gi +: 8] = (k_reg == 3'(gi + 1)) ? din_cap : buf_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    load_ext = buf_next;
    case (size_reg[1:0])
      2'b00:   load_ext = {{24{buf_next[7] & ~size_reg[2]}}, buf_next[7:0]};
      2'b01:   load_ext = {{16{buf_next[15] & ~size_reg[2]}}, buf_next[15:0]};
      default: load_ext = buf_next;
    endcase
  end

  assign wr_byte       = buf_reg[{k_inc[1:0], 3'b000} +: 8];
  assign store_blocked = (bus.data_addr[17:16] == 2'b11) && bus.io_buffer_full;
  assign req_n         = (bus.data_size[1:0] == 2'b00) ? 3'd1 :
                         (bus.data_size[1:0] == 2'b01) ? 3'd2 : 3'd4;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      buf_reg        <= '0;
      mem_a_reg      <= '0;
      inst_res_reg   <= '0;
      data_res_reg   <= '0;
      n_reg          <= 3'd0;
      k_reg          <= 3'd0;
      size_reg       <= 3'd0;
      owner_data_reg <= 1'b0;
      wr_reg         <= 1'b0;
      mem_dout_reg   <= 8'd0;
      mem_wr_reg     <= 1'b0;
      inst_ready_reg <= 1'b0;
      data_ready_reg <= 1'b0;
      rdy_q_reg      <= 1'b1;
      din_save_reg   <= 8'd0;
    end else begin
      rdy_q_reg <= rdy_in;
      if (rdy_q_reg) din_save_reg <= bus.mem_din;
      if (rdy_in) begin
        case (state_reg)
          IDLE: begin
            inst_ready_reg <= 1'b0;
            data_ready_reg <= 1'b0;
            if (bus.data_valid) begin
              if (bus.data_wr) begin
                if (!store_blocked) begin
                  addr_reg       <= bus.data_addr;
                  mem_a_reg      <= bus.data_addr;
                  mem_dout_reg   <= bus.data_value[7:0];
                  mem_wr_reg     <= 1'b1;
                  buf_reg        <= bus.data_value;
                  n_reg          <= req_n;
                  k_reg          <= 3'd0;
                  size_reg       <= bus.data_size;
                  owner_data_reg <= 1'b1;
                  wr_reg         <= 1'b1;
                  state_reg      <= WRITE;
                end
              end else if (!bus.clear) begin
                addr_reg       <= bus.data_addr;
                mem_a_reg      <= bus.data_addr;
                buf_reg        <= '0;
                n_reg          <= req_n;
                k_reg          <= 3'd0;
                size_reg       <= bus.data_size;
                owner_data_reg <= 1'b1;
                wr_reg         <= 1'b0;
                state_reg      <= READ;
              end
            end else if (bus.inst_valid && !bus.clear) begin
              addr_reg       <= bus.inst_addr;
              mem_a_reg      <= bus.inst_addr;
              buf_reg        <= '0;
              n_reg          <= 3'd4;
              k_reg          <= 3'd0;
              size_reg       <= 3'b010;
              owner_data_reg <= 1'b0;
              wr_reg         <= 1'b0;
              state_reg      <= READ;
            end
          end
          READ: begin
            if (bus.clear) begin
              mem_wr_reg <= 1'b0;
              state_reg  <= IDLE;
            end else begin
              if (k_reg != 3'd0) buf_reg <= buf_next;
              if (k_reg == n_reg) begin
                state_reg <= DONE;
                if (owner_data_reg) begin
                  data_ready_reg <= 1'b1;
                  data_res_reg   <= load_ext;
                end else begin
                  inst_ready_reg <= 1'b1;
                  inst_res_reg   <= buf_next;
                end
              end else begin
                if (k_inc != n_reg) mem_a_reg <= addr_reg + 32'(k_inc);
                k_reg <= k_inc;
              end
            end
          end
          WRITE: begin
            // Stores are committed: a clear here is deliberately ignored.
            if (k_inc != n_reg) begin
              mem_a_reg    <= addr_reg + 32'(k_inc);
              mem_dout_reg <= wr_byte;
              k_reg        <= k_inc;
            end else begin
              mem_wr_reg     <= 1'b0;
              data_ready_reg <= 1'b1;
              state_reg      <= DONE;
            end
          end
          DONE: begin
            inst_ready_reg <= 1'b0;
            data_ready_reg <= 1'b0;
            state_reg      <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.mem_a      = mem_a_reg;
  assign bus.mem_dout   = mem_dout_reg;
  assign bus.mem_wr     = mem_wr_reg & rdy_in;
  assign bus.inst_res   = inst_res_reg;
  assign bus.data_res   = data_res_reg;
  // A flush arriving in the completion cycle cancels a read's ready pulse.
  assign bus.inst_ready = inst_ready_reg & rdy_in & ~bus.clear;
  assign bus.data_ready = data_ready_reg & rdy_in & ~(bus.clear & ~wr_reg);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a transaction-level model schedules the expected
// bus activity and results per cycle, and one process compares every cycle.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en;

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit [7:0]  ref_mem [4096];
  bit [7:0]  bus_mem [4096];

  bit [31:0] exp_a     [int];
  bit [7:0]  exp_dout  [int];
  bit        exp_wr    [int];
  bit [31:0] exp_ires  [int];
  bit        exp_dready[int];
  bit [31:0] exp_dres  [int];

  function automatic bit [11:0] mi(bit [31:0] a);
    return {a[17:16], a[9:0]};
  endfunction

  function automatic bit [7:0] init_byte(bit [11:0] i);
    case (i)
      12'h100: return 8'h13;
      12'h101: return 8'h05;
      12'h020: return 8'h80;
      12'h010: return 8'h34;
      12'h011: return 8'h92;
      12'h200: return 8'h11;
      12'h201: return 8'h22;
      12'h202: return 8'h33;
      12'h203: return 8'h44;
      12'hFFF: return 8'h7F;
      12'h000: return 8'h81;
      default: return 8'h00;
    endcase
  endfunction

  // External memory: answers one cycle after the address, takes writes.
  initial begin
    for (int i = 0; i < 4096; i++) bus_mem[i] = init_byte(12'(i));
    forever begin
      @(posedge clk);
      bus.mem_din <= bus_mem[mi(bus.mem_a)];
      if (bus.mem_wr) bus_mem[mi(bus.mem_a)] = bus.mem_dout;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int size_bytes(bit [2:0] sz);
    return (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit [31:0] model_load(bit [31:0] a, int n, bit zx);
    bit [31:0]        raw = 0;
    bit signed [7:0]  sb;
    bit signed [15:0] sh;
    int               v;
    for (int k = 0; k < n; k++) raw = raw | (32'(ref_mem[mi(a + k)]) << (8 * k));
    if (n == 4 || zx) return raw;
    if (n == 1) begin sb = raw[7:0];  v = sb; end
    else        begin sh = raw[15:0]; v = sh; end
    return v;
  endfunction

  // Read accepted at cycle t; optional freeze of len cycles while index fk is shown.
  task automatic expect_read(bit inst, bit [31:0] a, bit [2:0] sz, int t,
                             int fk, int len, int na, bit deliver);
    int n = inst ? 4 : size_bytes(sz);
    for (int k = 0; k < na; k++) begin
      if (len == 0 || k < fk) exp_a[t + 1 + k] = a + k;
      else if (k == fk) for (int j = 0; j <= len; j++) exp_a[t + 1 + fk + j] = a + k;
      else exp_a[t + 1 + k + len] = a + k;
    end
    if (deliver) begin
      if (inst) exp_ires[t + n + 2 + len] = model_load(a, 4, 1'b1);
      else begin
        exp_dready[t + n + 2 + len] = 1'b1;
        exp_dres[t + n + 2 + len]   = model_load(a, n, sz[2]);
      end
    end
  endtask

  task automatic expect_write(bit [31:0] a, bit [2:0] sz, bit [31:0] v, int t);
    int n = size_bytes(sz);
    for (int k = 0; k < n; k++) begin
      exp_wr[t + 1 + k]   = 1'b1;
      exp_a[t + 1 + k]    = a + k;
      exp_dout[t + 1 + k] = v[8*k +: 8];
      ref_mem[mi(a + k)]  = v[8*k +: 8];
    end
    exp_dready[t + n + 1] = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_wr", 32'(bus.mem_wr), 32'(exp_wr.exists(cyc)));
      if (exp_a.exists(cyc)) check("mem_a", bus.mem_a, exp_a[cyc]);
      if (exp_wr.exists(cyc)) check("mem_dout", 32'(bus.mem_dout), 32'(exp_dout[cyc]));
      check("inst_ready", 32'(bus.inst_ready), 32'(exp_ires.exists(cyc)));
      if (exp_ires.exists(cyc)) check("inst_res", bus.inst_res, exp_ires[cyc]);
      check("data_ready", 32'(bus.data_ready), 32'(exp_dready.exists(cyc)));
      if (exp_dres.exists(cyc)) check("data_res", bus.data_res, exp_dres[cyc]);
    end
  end

  task automatic go_to(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic inst_req(bit [31:0] a);
    bus.inst_valid = 1'b1;
    bus.inst_addr  = a;
  endtask

  task automatic data_req(bit wr, bit [2:0] sz, bit [31:0] a, bit [31:0] v);
    bus.data_valid = 1'b1;
    bus.data_wr    = wr;
    bus.data_size  = sz;
    bus.data_addr  = a;
    bus.data_value = v;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_mem_a"}, bus.mem_a, 32'h0);
    check({tag, "_mem_dout"}, 32'(bus.mem_dout), 32'h0);
    check({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'h0);
    check({tag, "_inst_ready"}, 32'(bus.inst_ready), 32'h0);
    check({tag, "_data_ready"}, 32'(bus.data_ready), 32'h0);
    check({tag, "_inst_res"}, bus.inst_res, 32'h0);
    check({tag, "_data_res"}, bus.data_res, 32'h0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; chk_en = 1'b0;
    bus.clear = 1'b0; bus.io_buffer_full = 1'b0;
    bus.inst_valid = 1'b0; bus.inst_addr = '0;
    bus.data_valid = 1'b0; bus.data_wr = 1'b0; bus.data_size = '0;
    bus.data_addr = '0; bus.data_value = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(12'(i));

    go_to(2);
    check_all_zero("reset");
    go_to(3); rst = 1'b0;
    go_to(4); chk_en = 1'b1;

    // Fetch 0x100 -> 0x00000513 at T+6
    expect_read(1'b1, 32'h100, 3'b010, 10, 0, 0, 4, 1'b1);
    go_to(10); inst_req(32'h100);
    go_to(17); bus.inst_valid = 1'b0;
    check("pin_fetch", bus.inst_res, 32'h0000_0513);

    // Signed and unsigned byte loads of 0x80
    expect_read(1'b0, 32'h20, 3'b000, 20, 0, 0, 1, 1'b1);
    go_to(20); data_req(1'b0, 3'b000, 32'h20, 0);
    go_to(24); bus.data_valid = 1'b0;
    check("pin_lb", bus.data_res, 32'hFFFF_FF80);
    expect_read(1'b0, 32'h20, 3'b100, 25, 0, 0, 1, 1'b1);
    go_to(25); data_req(1'b0, 3'b100, 32'h20, 0);
    go_to(29); bus.data_valid = 1'b0;
    check("pin_lbu", bus.data_res, 32'h0000_0080);

    // Word store
    expect_write(32'h40, 3'b010, 32'hDEAD_BEEF, 30);
    go_to(30); data_req(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
    go_to(36); bus.data_valid = 1'b0;

    // Simultaneous requests: data first, fetch accepted at T+5
    expect_read(1'b0, 32'h10, 3'b001, 40, 0, 0, 2, 1'b1);
    expect_read(1'b1, 32'h100, 3'b010, 45, 0, 0, 4, 1'b1);
    go_to(40); data_req(1'b0, 3'b001, 32'h10, 0); inst_req(32'h100);
    go_to(45); bus.data_valid = 1'b0;
    check("pin_lh", bus.data_res, 32'hFFFF_9234);
    go_to(52); bus.inst_valid = 1'b0;

    // IO store held off by a full UART buffer, fetch also blocked
    expect_write(32'h0003_0000, 3'b000, 32'h41, 70);
    expect_read(1'b1, 32'h100, 3'b010, 73, 0, 0, 4, 1'b1);
    go_to(60); bus.io_buffer_full = 1'b1;
    data_req(1'b1, 3'b000, 32'h0003_0000, 32'h41); inst_req(32'h100);
    go_to(70); bus.io_buffer_full = 1'b0;
    go_to(73); bus.data_valid = 1'b0;
    go_to(80); bus.inst_valid = 1'b0;

    // Clear at T+3 of a fetch aborts; block is IDLE at T+4
    expect_read(1'b1, 32'h100, 3'b010, 90, 0, 0, 3, 1'b0);
    expect_read(1'b0, 32'h20, 3'b100, 94, 0, 0, 1, 1'b1);
    go_to(90); inst_req(32'h100);
    go_to(93); bus.clear = 1'b1;
    go_to(94); bus.clear = 1'b0; bus.inst_valid = 1'b0;
    data_req(1'b0, 3'b100, 32'h20, 0);
    go_to(98); bus.data_valid = 1'b0;

    // Clear at T+2 of a store is ignored
    expect_write(32'h50, 3'b010, 32'h1122_3344, 100);
    go_to(100); data_req(1'b1, 3'b010, 32'h50, 32'h1122_3344);
    go_to(102); bus.clear = 1'b1;
    go_to(103); bus.clear = 1'b0;
    go_to(106); bus.data_valid = 1'b0;

    // Clear in the completion cycle of a fetch suppresses inst_ready
    expect_read(1'b1, 32'h100, 3'b010, 110, 0, 0, 4, 1'b0);
    go_to(110); inst_req(32'h100);
    go_to(116); bus.clear = 1'b1;
    go_to(117); bus.clear = 1'b0; bus.inst_valid = 1'b0;

    // Clear in IDLE delays a load by one cycle
    expect_read(1'b0, 32'h20, 3'b000, 121, 0, 0, 1, 1'b1);
    go_to(120); bus.clear = 1'b1; data_req(1'b0, 3'b000, 32'h20, 0);
    go_to(121); bus.clear = 1'b0;
    go_to(125); bus.data_valid = 1'b0;

    // Three-cycle freeze mid-fetch: word arrives three cycles late
    expect_read(1'b1, 32'h200, 3'b010, 130, 2, 3, 4, 1'b1);
    go_to(130); inst_req(32'h200);
    go_to(133); rdy = 1'b0;
    go_to(136); rdy = 1'b1;
    go_to(140); bus.inst_valid = 1'b0;
    check("pin_freeze", bus.inst_res, 32'h4433_2211);

    // Asynchronous reset in the middle of a store
    exp_wr[151] = 1'b1; exp_a[151] = 32'h60; exp_dout[151] = 8'h0D;
    go_to(150); data_req(1'b1, 3'b010, 32'h60, 32'hCAFE_F00D);
    go_to(152); chk_en = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    bus.data_valid = 1'b0;
    go_to(154); rst = 1'b0;
    go_to(155); chk_en = 1'b1;
    expect_read(1'b0, 32'h20, 3'b000, 156, 0, 0, 1, 1'b1);
    go_to(156); data_req(1'b0, 3'b000, 32'h20, 0);
    go_to(160); bus.data_valid = 1'b0;

    // Read back the stored word, an unaligned half, and a wrapping half
    expect_read(1'b0, 32'h40, 3'b010, 165, 0, 0, 4, 1'b1);
    go_to(165); data_req(1'b0, 3'b010, 32'h40, 0);
    go_to(172); bus.data_valid = 1'b0;
    check("pin_lw", bus.data_res, 32'hDEAD_BEEF);
    expect_read(1'b0, 32'h41, 3'b101, 175, 0, 0, 2, 1'b1);
    go_to(175); data_req(1'b0, 3'b101, 32'h41, 0);
    go_to(180); bus.data_valid = 1'b0;
    check("pin_lhu_unaligned", bus.data_res, 32'h0000_ADBE);
    expect_read(1'b0, 32'hFFFF_FFFF, 3'b001, 185, 0, 0, 2, 1'b1);
    go_to(185); data_req(1'b0, 3'b001, 32'hFFFF_FFFF, 0);
    go_to(190); bus.data_valid = 1'b0;
    check("pin_lh_wrap", bus.data_res, 32'hFFFF_817F);

    go_to(195);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the CPU's internal instruction-fetch and load/store requesters and the external 8-bit memory/IO bus. It arbitrates one instruction port (4-byte fetch) and one data port (1/2/4-byte load or store), sequences the per-byte bus cycles, and assembles little-endian results with sign or zero extension. It also enforces the UART back-pressure rule and aborts speculative reads on a pipeline clear.

## Interface
- No parameters.
- clk_in  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-high
- rdy_in  in  1  global enable; all state frozen when low
- mem_din  in  8  byte returned from memory, one cycle after its address
- mem_dout  out  8  write byte
- mem_a  out  32  byte address; bits 17:16 == 2'b11 selects IO
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  UART transmit buffer full
- clear  in  1  pipeline flush from the reorder buffer
- inst_valid  in  1  fetch request; held until inst_ready
- inst_addr  in  32  fetch address (word aligned)
- inst_ready  out  1  one-cycle pulse; inst_res valid
- inst_res  out  32  fetched word
- data_valid  in  1  load/store request; held until data_ready
- data_wr  in  1  1 = store
- data_size  in  3  [1:0]: 00 byte, 01 half, 10 word; [2]: 1 = zero-extend load
- data_addr  in  32  byte address
- data_value  in  32  store data, byte k = data_value[8k+7:8k]
- data_ready  out  1  one-cycle pulse; data_res valid (loads), store done
- data_res  out  32  extended load result

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: addr, byte count n (1/2/4), index k (0..4), 32-bit assembly buffer, owner (INST/DATA), size.
- Reset: state IDLE; mem_a=0, mem_dout=0, mem_wr=0, inst_ready=0, data_ready=0, inst_res=0, data_res=0, buffer=0.
- IDLE arbitration: data_valid wins over inst_valid. A store whose address has bits 17:16 == 2'b11 is not started while io_buffer_full=1; in that case the block stays IDLE and does not serve a fetch either. A clear in IDLE suppresses starting a read that cycle.
- READ: drive mem_a = addr+k for k=0..n-1, mem_wr=0. Capture mem_din into buffer byte k one cycle after address k. After the last capture, go to DONE.
- WRITE: drive mem_a = addr+k, mem_dout = byte k, mem_wr=1 for k=0..n-1, then go to DONE.
- DONE: pulse the owner's ready for one cycle and go back to IDLE. A new request is not accepted in the DONE cycle.
- Load extension: byte/half sign-extend from bit 7/15 when data_size[2]=0, zero-extend when it is 1. Word loads are unchanged. inst_res is the raw word.
- clear during READ (either owner): abort to IDLE with mem_wr=0. No ready pulse, and the partial buffer is discarded.
- clear during WRITE: ignored. Committed stores always complete and pulse data_ready.
- clear during DONE for a read: the ready pulse is suppressed.
- rdy_in low: all registers hold, mem_wr is forced to 0, and mem_a holds its value. Capture resumes on the first rdy_in-high cycle using mem_din for the held address. IO reads at 0x30000 may therefore be read twice; software does not read input across a freeze.
- addr+k wraps modulo 2^32. Unaligned halves and words are sequenced byte-wise with no fault.

## Timing
- T = the IDLE cycle in which a request is accepted. All outputs are registered.
- Read of n bytes: mem_a = addr+k during T+1+k; byte k captured at the end of T+2+k; ready/res high during T+n+2.
  - Fetch: ready at T+6.
  - Byte load: ready at T+3.
- Write of n bytes: mem_wr=1 during T+1..T+n; data_ready high during T+n+1.
- Back-to-back: the earliest next acceptance is T+n+3 for reads and T+n+2 for writes.
- res keeps its value until the next ready pulse for that port.

## Test plan
- Fetch at 0x100, memory bytes 13,05,00,00 -> inst_ready at T+6 with inst_res=0x00000513. mem_a runs 0x100..0x103 in T+1..T+4.
- Load byte signed from 0x20 = 0x80 -> data_res=0xFFFFFF80 at T+3. Same request with data_size=3'b100 -> data_res=0x00000080.
- Store word 0xDEADBEEF to 0x40 -> mem_wr=1 in T+1..T+4 with (mem_a, mem_dout) = (0x40,EF), (0x41,BE), (0x42,AD), (0x43,DE); data_ready at T+5.
- Simultaneous inst_valid and data_valid (load half at 0x10) -> the data access is served first and the fetch starts at T+5. Separately: store byte 0x41 to 0x30000 with io_buffer_full=1 for 10 cycles -> mem_wr stays 0 and no fetch is served; the write is issued in the cycle after io_buffer_full drops.
- clear asserted at T+3 of a fetch -> no inst_ready, state IDLE at T+4. clear at T+2 of a word store -> all 4 bytes written and data_ready at T+5.
- rdy_in low for 3 cycles mid-fetch -> mem_wr=0, mem_a frozen, and a correct word delivered 3 cycles late. rst_in pulsed mid-write -> all outputs 0 immediately (asynchronous), state IDLE.
